// File: rtl/mac_sniffer_pkg.sv
// mac_sniffer_pkg: shared types and constants for the MAC sniffer.
// Holds the frame sequencer state encoding and default timing values.
package mac_sniffer_pkg;
  localparam int MAC_W = 48;
  localparam int WORD_W = 32;
  localparam int MATCH_LAT_DEF = 3;
  localparam int MIN_WORDS_DEF = 16;
  localparam int MAX_WORDS_DEF = 380;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DRAIN,
    REPORT,
    CLEAR
  } ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Used for the frame, match and drop statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next value: bump unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mac_match_ctrl.sv
// mac_match_ctrl: frame sequencer around the MAC comparator.
// Gates words in, clears between frames, reports one result per frame.
module mac_match_ctrl
  import mac_sniffer_pkg::*;
#(
  parameter int MATCH_LAT = MATCH_LAT_DEF,
  parameter int MIN_WORDS = MIN_WORDS_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              sof,
  input  logic              eof,
  output logic              rx_ready,
  input  logic              cfg_wr,
  input  logic [MAC_W-1:0]  cfg_mac,
  output logic              cfg_pending,
  output logic [WORD_W-1:0] cmp_data,
  output logic              cmp_clear,
  output logic [MAC_W-1:0]  cmp_flagged_mac,
  input  logic              cmp_match,
  output logic              frame_done,
  output logic              frame_flagged,
  output logic              frame_runt,
  output logic              frame_abort,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  drop_count
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  localparam int LT_W = $clog2(MATCH_LAT + 1);

  ctrl_state_t      state_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [LT_W-1:0]  lat_q;
  logic             rdy_q;
  logic             done_q;
  logic             flag_q;
  logic             runt_q;
  logic             clr_q;
  logic [MAC_W-1:0] mac_q;
  logic [MAC_W-1:0] pmac_q;
  logic             pend_q;

  logic sof_ev;
  logic abort;
  logic apply;
  logic last_word;

  // frame events and mid-frame abort detection
  always_comb begin
    sof_ev    = sof & data_valid;
    last_word = (wcnt_q == WC_W'(MAX_WORDS - 1));
    abort     = !data_valid || sof || (!eof && last_word);
    apply     = pend_q &&
                ((state_q == IDLE && !sof_ev) || state_q == CLEAR);
  end

  // word gating towards the comparator
  always_comb begin
    cmp_data = '0;
    if (data_valid && (state_q == RECV || (state_q == IDLE && sof)))
      cmp_data = data_in;
  end

  // frame sequencer with registered outputs and config staging
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      lat_q   <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
      runt_q  <= 1'b0;
      clr_q   <= 1'b0;
      mac_q   <= '0;
      pmac_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      flag_q <= 1'b0;
      runt_q <= 1'b0;
      clr_q  <= 1'b0;
      if (cfg_wr) begin
        pmac_q <= cfg_mac;
        pend_q <= 1'b1;
      end
      // a write landing on the apply cycle stays pending
      if (apply) begin
        mac_q <= pmac_q;
        if (!cfg_wr) pend_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (sof_ev) begin
            rdy_q   <= 1'b0;
            wcnt_q  <= WC_W'(1);
            lat_q   <= '0;
            state_q <= eof ? DRAIN : RECV;
          end
        end
        RECV: begin
          if (abort) begin
            clr_q   <= 1'b1;
            state_q <= CLEAR;
          end else if (eof) begin
            wcnt_q  <= wcnt_q + 1'b1;
            lat_q   <= '0;
            state_q <= DRAIN;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (lat_q == LT_W'(MATCH_LAT - 1)) begin
            done_q  <= 1'b1;
            runt_q  <= (wcnt_q < WC_W'(MIN_WORDS));
            flag_q  <= cmp_match && (wcnt_q >= WC_W'(MIN_WORDS))
                       && (mac_q != '0);
            state_q <= REPORT;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        REPORT: begin
          clr_q   <= 1'b1;
          state_q <= CLEAR;
        end
        CLEAR: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready        = rdy_q;
  assign cfg_pending     = pend_q;
  assign cmp_clear       = clr_q;
  assign cmp_flagged_mac = mac_q;
  assign frame_done      = done_q;
  assign frame_flagged   = flag_q;
  assign frame_runt      = runt_q;
  assign frame_abort     = (state_q == RECV) && abort;

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (done_q),
    .cnt_o (frame_count)
  );

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (done_q & flag_q),
    .cnt_o (match_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (sof_ev & ~rdy_q),
    .cnt_o (drop_count)
  );
endmodule

// File: tb/tb_mac_match_ctrl.sv
// tb_mac_match_ctrl: directed checks for the frame sequencer.
// Counters run at 4 bits so saturation is reachable quickly.
module tb_mac_match_ctrl;
  localparam int CW = 4;
  localparam logic [47:0] MAC_A = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] MAC_B = 48'h112233445566;
  localparam logic [47:0] MAC_C = 48'h000000000001;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   data_in;
  logic          data_valid, sof, eof;
  logic          rx_ready;
  logic          cfg_wr;
  logic [47:0]   cfg_mac;
  logic          cfg_pending;
  logic [31:0]   cmp_data;
  logic          cmp_clear;
  logic [47:0]   cmp_flagged_mac;
  logic          cmp_match;
  logic          frame_done, frame_flagged, frame_runt, frame_abort;
  logic [CW-1:0] frame_count, match_count, drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  mac_match_ctrl #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .sof             (sof),
    .eof             (eof),
    .rx_ready        (rx_ready),
    .cfg_wr          (cfg_wr),
    .cfg_mac         (cfg_mac),
    .cfg_pending     (cfg_pending),
    .cmp_data        (cmp_data),
    .cmp_clear       (cmp_clear),
    .cmp_flagged_mac (cmp_flagged_mac),
    .cmp_match       (cmp_match),
    .frame_done      (frame_done),
    .frame_flagged   (frame_flagged),
    .frame_runt      (frame_runt),
    .frame_abort     (frame_abort),
    .frame_count     (frame_count),
    .match_count     (match_count),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not end, got timeout, want $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    data_valid = 1'b0;
    sof = 1'b0;
    eof = 1'b0;
    data_in = '0;
    cfg_wr = 1'b0;
  endtask

  function automatic logic [31:0] fword(input int i);
    case (i)
      0:       return 32'hFFFF_FFFF;
      1:       return {16'hFFFF, MAC_A[47:32]};
      2:       return MAC_A[31:0];
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  task automatic do_cfg(input logic [47:0] val, input logic [47:0] old);
    tick;
    cfg_wr = 1'b1;
    cfg_mac = val;
    tick;
    cfg_wr = 1'b0;
    chk("cfg_pend_set", 64'(cfg_pending), 64'd1);
    chk("cfg_mac_old", 64'(cmp_flagged_mac), 64'(old));
    tick;
    chk("cfg_mac_new", 64'(cmp_flagged_mac), 64'(val));
    chk("cfg_pend_clr", 64'(cfg_pending), 64'd0);
  endtask

  // leaves the bench inside the last driven word's cycle
  task automatic send_frame(input int n, input bit has_eof, input bit hit,
                            input int cfg_at, input logic [47:0] cval);
    int hit_at;
    hit_at = (n < 4) ? n - 1 : 3;
    for (int i = 0; i < n; i++) begin
      tick;
      data_valid = 1'b1;
      sof = (i == 0);
      eof = has_eof && (i == n - 1);
      data_in = fword(i);
      cfg_wr = (i == cfg_at);
      cfg_mac = cval;
      if (hit && i == hit_at) cmp_match = 1'b1;
      #1;
      if (i == 0) chk("cmp_data_sof", 64'(cmp_data), 64'(data_in));
      if (i == 1) begin
        chk("rx_ready_busy", 64'(rx_ready), 64'd0);
        chk("cmp_data_recv", 64'(cmp_data), 64'(data_in));
      end
    end
  endtask

  // called in cycle e; ends in cycle e+6
  task automatic finish_frame(input bit ef, input bit er, input int fc,
                              input int mc, input bit pend,
                              input bit inj_sof, input int late);
    tick;
    idle_in();
    #1;
    chk("cmp_data_gated", 64'(cmp_data), 64'd0);
    tick;
    if (inj_sof) begin
      data_valid = 1'b1;
      sof = 1'b1;
      eof = 1'b1;
      data_in = 32'hDEAD_BEEF;
      #1;
      chk("cmp_data_drop", 64'(cmp_data), 64'd0);
    end
    tick;
    idle_in();
    if (late == 3) cmp_match = 1'b1;
    chk("done_early", 64'(frame_done), 64'd0);
    tick;
    if (late == 4) cmp_match = 1'b1;
    chk("done", 64'(frame_done), 64'd1);
    chk("flagged", 64'(frame_flagged), 64'(ef));
    chk("runt", 64'(frame_runt), 64'(er));
    chk("clear_early", 64'(cmp_clear), 64'd0);
    tick;
    cmp_match = 1'b0;
    chk("done_pulse", 64'(frame_done), 64'd0);
    chk("cmp_clear", 64'(cmp_clear), 64'd1);
    chk("rx_ready_clr", 64'(rx_ready), 64'd0);
    chk("frame_count", 64'(frame_count), 64'(fc));
    chk("match_count", 64'(match_count), 64'(mc));
    chk("pend_at_clr", 64'(cfg_pending), 64'(pend));
    tick;
    chk("rx_ready_back", 64'(rx_ready), 64'd1);
    chk("clear_pulse", 64'(cmp_clear), 64'd0);
  endtask

  initial begin
    int efc, emc;
    rst = 1'b1;
    cmp_match = 1'b0;
    cfg_mac = '0;
    idle_in();
    tick;
    tick;
    rst = 1'b0;
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_clear", 64'(cmp_clear), 64'd0);
    chk("rst_mac", 64'(cmp_flagged_mac), 64'd0);
    chk("rst_pend", 64'(cfg_pending), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);

    do_cfg(MAC_A, 48'd0);
    send_frame(20, 1, 1, -1, '0);
    finish_frame(1, 0, 1, 1, 0, 0, 0);

    do_cfg(MAC_B, MAC_A);
    send_frame(20, 1, 0, -1, '0);
    finish_frame(0, 0, 2, 1, 0, 0, 0);

    send_frame(10, 1, 1, -1, '0);
    finish_frame(0, 1, 3, 1, 0, 0, 0);

    send_frame(20, 1, 0, -1, '0);
    finish_frame(0, 0, 4, 1, 0, 1, 0);
    chk("drop_count1", 64'(drop_count), 64'd1);

    send_frame(6, 0, 0, -1, '0);
    chk("no_abort_w6", 64'(frame_abort), 64'd0);
    tick;
    idle_in();
    #1;
    chk("abort_dv", 64'(frame_abort), 64'd1);
    chk("abort_gate", 64'(cmp_data), 64'd0);
    tick;
    chk("abort_clear", 64'(cmp_clear), 64'd1);
    chk("abort_pulse", 64'(frame_abort), 64'd0);
    chk("abort_nodone", 64'(frame_done), 64'd0);
    tick;
    chk("abort_rdy", 64'(rx_ready), 64'd1);
    chk("abort_fc", 64'(frame_count), 64'd4);

    send_frame(5, 0, 0, -1, '0);
    tick;
    data_valid = 1'b1;
    sof = 1'b1;
    data_in = 32'h1234_5678;
    #1;
    chk("abort_sof", 64'(frame_abort), 64'd1);
    tick;
    idle_in();
    chk("abort_sof_clr", 64'(cmp_clear), 64'd1);
    chk("drop_count2", 64'(drop_count), 64'd2);
    tick;

    send_frame(379, 0, 0, -1, '0);
    chk("no_abort_379", 64'(frame_abort), 64'd0);
    tick;
    sof = 1'b0;
    data_in = 32'h0000_0380;
    #1;
    chk("abort_max", 64'(frame_abort), 64'd1);
    tick;
    idle_in();
    chk("abort_max_clr", 64'(cmp_clear), 64'd1);
    tick;
    chk("abort_max_fc", 64'(frame_count), 64'd4);

    send_frame(380, 1, 0, -1, '0);
    chk("no_abort_380e", 64'(frame_abort), 64'd0);
    finish_frame(0, 0, 5, 1, 0, 0, 0);

    send_frame(1, 1, 1, -1, '0);
    finish_frame(0, 1, 6, 1, 0, 0, 0);

    send_frame(20, 1, 1, 5, MAC_C);
    chk("mid_pend", 64'(cfg_pending), 64'd1);
    chk("mid_mac_old", 64'(cmp_flagged_mac), 64'(MAC_B));
    finish_frame(1, 0, 7, 2, 1, 0, 0);
    chk("mid_mac_new", 64'(cmp_flagged_mac), 64'(MAC_C));
    chk("mid_pend_clr", 64'(cfg_pending), 64'd0);

    send_frame(20, 1, 0, -1, '0);
    finish_frame(1, 0, 8, 3, 0, 0, 3);
    send_frame(20, 1, 0, -1, '0);
    finish_frame(0, 0, 9, 3, 0, 0, 4);

    do_cfg(48'd0, MAC_C);
    send_frame(20, 1, 1, -1, '0);
    finish_frame(0, 0, 10, 3, 0, 0, 0);

    do_cfg(MAC_A, 48'd0);
    for (int i = 1; i <= (1 << CW) + 2; i++) begin
      efc = (10 + i > 15) ? 15 : 10 + i;
      emc = (3 + i > 15) ? 15 : 3 + i;
      send_frame(20, 1, 1, -1, '0);
      finish_frame(1, 0, efc, emc, 0, 0, 0);
    end
    chk("sat_match", 64'(match_count), 64'hF);
    chk("sat_frame", 64'(frame_count), 64'hF);
    chk("drop_final", 64'(drop_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
